// File: rtl/load_store_unit_if.sv
// Request/response handshake between the pipeline and the load/store unit.
// The pipeline is the master; the load/store unit is the slave.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/load_store_unit.sv
// RV64 load/store initiator for an 8-byte-wide little-endian data memory.
// Sub-doubleword stores are done as read-modify-write of the full 8 bytes.
//
//   state  | meaning
//   IDLE   | ready to accept a request
//   RD     | MemRead asserted, memory samples Mem_Addr
//   CAP    | Read_Data valid: extend load data or build store merge buffer
//   WR     | MemWrite asserted with merge buffer on Write_Data
//   RESP   | one-cycle response pulse
module load_store_unit #(
    parameter int MEM_BYTES = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    load_store_unit_if.slave   req,
    output logic [63:0]        Mem_Addr,
    output logic [63:0]        Write_Data,
    output logic               MemWrite,
    output logic               MemRead,
    input  logic [63:0]        Read_Data
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_RESP} state_t;

    localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

    state_t      state, state_nxt;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] merge_q;
    logic [63:0] rdata_q;
    logic        error_q;

    logic        accept;
    logic        misaligned;
    logic        illegal;
    logic        req_err;
    logic        sign;
    logic [63:0] load_ext;
    logic [63:0] merged;

    always_comb begin
        accept     = req.req_valid && (state == S_IDLE);
        misaligned = 1'b0;
        case (req.req_funct3[1:0])
            2'b01:   misaligned = req.req_addr[0];
            2'b10:   misaligned = (req.req_addr[1:0] != 2'b00);
            2'b11:   misaligned = (req.req_addr[2:0] != 3'b000);
            default: misaligned = 1'b0;
        endcase
        illegal = req.req_write ? req.req_funct3[2] : (req.req_funct3 == 3'b111);
        req_err = (req.req_addr > ADDR_MAX) || misaligned || illegal;
    end

    always_comb begin
        sign     = ~funct3_q[2];
        load_ext = Read_Data;
        merged   = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                load_ext = {{56{sign & Read_Data[7]}}, Read_Data[7:0]};
                merged   = {Read_Data[63:8], wdata_q[7:0]};
            end
            2'b01: begin
                load_ext = {{48{sign & Read_Data[15]}}, Read_Data[15:0]};
                merged   = {Read_Data[63:16], wdata_q[15:0]};
            end
            2'b10: begin
                load_ext = {{32{sign & Read_Data[31]}}, Read_Data[31:0]};
                merged   = {Read_Data[63:32], wdata_q[31:0]};
            end
            default: begin
                load_ext = Read_Data;
                merged   = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_nxt = S_RESP;
                    else if (req.req_write && (req.req_funct3[1:0] == 2'b11))
                        state_nxt = S_WR;
                    else
                        state_nxt = S_RD;
                end
            end
            S_RD:    state_nxt = S_CAP;
            S_CAP:   state_nxt = write_q ? S_WR : S_RESP;
            S_WR:    state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 64'd0;
            wdata_q  <= 64'd0;
            merge_q  <= 64'd0;
            rdata_q  <= 64'd0;
            error_q  <= 1'b0;
        end else if (accept) begin
            write_q  <= req.req_write;
            funct3_q <= req.req_funct3;
            addr_q   <= req.req_addr;
            wdata_q  <= req.req_wdata;
            // SD skips the read, so the buffer is loaded verbatim here
            merge_q  <= req.req_wdata;
            rdata_q  <= 64'd0;
            error_q  <= req_err;
        end else if (state == S_CAP) begin
            if (write_q)
                merge_q <= merged;
            else
                rdata_q <= load_ext;
        end
    end

    assign req.req_ready  = (state == S_IDLE);
    assign req.resp_valid = (state == S_RESP);
    assign req.resp_rdata = rdata_q;
    assign req.resp_error = error_q;
    assign Mem_Addr       = addr_q;
    assign Write_Data     = merge_q;
    assign MemRead        = (state == S_RD);
    assign MemWrite       = (state == S_WR);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory model, queue scoreboard and
// a byte-level reference model of RV64 load/store semantics.
module tb_load_store_unit;
    localparam int MEM_BYTES = 64;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          rd_n;
        int          wr_n;
        logic [63:0] addr;
        logic [63:0] wdat;
        int          acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] Mem_Addr;
    logic [63:0] Write_Data;
    logic        MemWrite;
    logic        MemRead;
    logic [63:0] Read_Data = 64'd0;

    load_store_unit_if bus();

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (bus),
        .Mem_Addr   (Mem_Addr),
        .Write_Data (Write_Data),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .Read_Data  (Read_Data)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [MEM_BYTES];
    logic [7:0] ref_mem [MEM_BYTES];

    // Memory registers read data on the edge where MemRead is high
    always @(posedge clk) begin
        if (MemRead && Mem_Addr <= 64'(MEM_BYTES - 8))
            for (int i = 0; i < 8; i++)
                Read_Data[8*i +: 8] <= mem[int'(Mem_Addr[31:0]) + i];
        if (MemWrite && Mem_Addr <= 64'(MEM_BYTES - 8))
            for (int i = 0; i < 8; i++)
                mem[int'(Mem_Addr[31:0]) + i] <= Write_Data[8*i +: 8];
    end

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic w, input logic [2:0] f3,
                                   input logic [63:0] a, input logic [63:0] d,
                                   input logic apply);
        exp_t e;
        int   n;
        int   base;
        logic bad;
        n = 1 << f3[1:0];
        bad = (a > 64'(MEM_BYTES - 8)) || ((a % 64'(n)) != 64'd0) ||
              (w ? (f3 > 3'd3) : (f3 == 3'd7));
        e.addr = a; e.wdat = 64'd0; e.rdata = 64'd0; e.err = bad;
        e.acc_cyc = 0;
        if (bad) begin
            e.lat = 1; e.rd_n = 0; e.wr_n = 0;
        end else begin
            base = int'(a[31:0]);
            if (!w) begin
                for (int i = 0; i < n; i++)
                    e.rdata = e.rdata | (64'(ref_mem[base + i]) << (8 * i));
                if (!f3[2] && n < 8 && e.rdata[8*n - 1])
                    e.rdata = e.rdata | (~64'd0 << (8 * n));
                e.lat = 3; e.rd_n = 1; e.wr_n = 0;
            end else begin
                if (apply)
                    for (int i = 0; i < n; i++)
                        ref_mem[base + i] = d[8*i +: 8];
                for (int i = 0; i < 8; i++)
                    e.wdat[8*i +: 8] = (i < n) ? d[8*i +: 8] : ref_mem[base + i];
                e.lat  = (n == 8) ? 2 : 4;
                e.rd_n = (n == 8) ? 0 : 1;
                e.wr_n = 1;
            end
        end
        return e;
    endfunction

    // Scoreboard monitor
    int rd_seen = 0;
    int wr_seen = 0;
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!reset_n) begin
            rd_seen = 0;
            wr_seen = 0;
        end else begin
            if (MemRead || MemWrite || bus.resp_valid)
                chk("ready_when_busy", 64'(bus.req_ready), 64'd0);
            if (MemRead || MemWrite) begin
                if (q.size() == 0) begin
                    chk("orphan_strobe", {62'd0, MemRead, MemWrite}, 64'd0);
                end else begin
                    chk("mem_addr", Mem_Addr, q[0].addr);
                    if (MemRead) rd_seen++;
                    if (MemWrite) begin
                        wr_seen++;
                        chk("write_data", Write_Data, q[0].wdat);
                    end
                end
            end
            if (bus.resp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", 64'(bus.resp_valid), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("resp_rdata", bus.resp_rdata, e.rdata);
                    chk("resp_error", 64'(bus.resp_error), 64'(e.err));
                    chk("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
                    chk("memread_cycles", 64'(rd_seen), 64'(e.rd_n));
                    chk("memwrite_cycles", 64'(wr_seen), 64'(e.wr_n));
                    rd_seen = 0;
                    wr_seen = 0;
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] d, input logic apply);
        exp_t e;
        int   guard;
        guard = 0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        while (!bus.req_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 20) begin
                chk("accept_timeout", 64'(bus.req_ready), 64'd1);
                bus.req_valid = 1'b0;
                return;
            end
        end
        e = model(w, f3, a, d, apply);
        e.acc_cyc = cyc;
        q.push_back(e);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++)
            @(negedge clk);
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t        e;
        int          acc1;
        int          guard;
        logic [63:0] a;
        for (int i = 0; i < MEM_BYTES; i++) begin
            mem[i]     = 8'h0D;
            ref_mem[i] = 8'h0D;
        end
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 64'd0;
        bus.req_wdata  = 64'd0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_error", 64'(bus.resp_error), 64'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
        chk("rst_mem_addr", Mem_Addr, 64'd0);
        chk("rst_write_data", Write_Data, 64'd0);
        chk("rst_strobes", {62'd0, MemRead, MemWrite}, 64'd0);
        reset_n = 1'b1;

        issue(1'b0, 3'd3, 64'd0, 64'd0, 1'b1);
        issue(1'b1, 3'd0, 64'd8, 64'h11223344556677AB, 1'b1);
        issue(1'b0, 3'd3, 64'd8, 64'd0, 1'b1);
        issue(1'b0, 3'd0, 64'd8, 64'd0, 1'b1);
        issue(1'b0, 3'd4, 64'd8, 64'd0, 1'b1);
        issue(1'b1, 3'd2, 64'd16, 64'h0000000080000000, 1'b1);
        issue(1'b0, 3'd2, 64'd16, 64'd0, 1'b1);
        issue(1'b0, 3'd6, 64'd16, 64'd0, 1'b1);
        issue(1'b0, 3'd3, 64'd16, 64'd0, 1'b1);
        issue(1'b1, 3'd1, 64'd9, 64'hFFFF, 1'b1);
        issue(1'b0, 3'd3, 64'd57, 64'd0, 1'b1);
        issue(1'b0, 3'd7, 64'd0, 64'd0, 1'b1);
        issue(1'b0, 3'd3, 64'd56, 64'd0, 1'b1);
        issue(1'b0, 3'd3, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b1);
        drain();

        // Two SDs with req_valid held high throughout
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'd3;
        bus.req_addr   = 64'd0;
        bus.req_wdata  = 64'hA1A2A3A4A5A6A7A8;
        e = model(1'b1, 3'd3, 64'd0, 64'hA1A2A3A4A5A6A7A8, 1'b1);
        e.acc_cyc = cyc;
        acc1 = cyc;
        q.push_back(e);
        @(posedge clk);
        #1;
        bus.req_addr  = 64'd24;
        bus.req_wdata = 64'hB1B2B3B4B5B6B7B8;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus.req_ready && guard < 20);
        e = model(1'b1, 3'd3, 64'd24, 64'hB1B2B3B4B5B6B7B8, 1'b1);
        e.acc_cyc = cyc;
        q.push_back(e);
        chk("b2b_accept_gap", 64'(cyc - acc1), 64'd3);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        issue(1'b0, 3'd3, 64'd0, 64'd0, 1'b1);
        issue(1'b0, 3'd3, 64'd24, 64'd0, 1'b1);
        drain();

        // Reset during CAP of an SB: no write, no response
        issue(1'b1, 3'd0, 64'd32, 64'h55, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rst_mid_memwrite", 64'(MemWrite), 64'd0);
            chk("rst_mid_resp", 64'(bus.resp_valid), 64'd0);
            @(negedge clk);
        end
        q.delete();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_memwrite", 64'(MemWrite), 64'd0);
            chk("post_rst_resp", 64'(bus.resp_valid), 64'd0);
        end
        issue(1'b0, 3'd3, 64'd32, 64'd0, 1'b1);
        drain();

        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 9) == 0)
                a = {$urandom, $urandom};
            else if ($urandom_range(0, 1) == 0)
                a = 64'($urandom_range(0, 7) * 8);
            else
                a = 64'($urandom_range(0, 63));
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
                  {$urandom, $urandom}, 1'b1);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Pipeline-side initiator for the byte-addressed, little-endian 64-bit Data_Memory port (Mem_Addr, Write_Data, MemWrite, MemRead, Read_Data).
- Accepts one RV64 load/store request at a time over a valid/ready handshake and drives the memory strobes.
- Extracts and sign- or zero-extends load data.
- Performs read-modify-write for SB/SH/SW, because the memory always writes 8 bytes starting at Mem_Addr.
- Returns a single-cycle response pulse, with an error flag for misaligned, out-of-range or illegal requests.

Parameters:
- MEM_BYTES, 64, byte capacity of the attached memory; legal addresses are 0..MEM_BYTES-8.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV64 funct3. Loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU. Stores: 000 SB, 001 SH, 010 SW, 011 SD.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data, low bytes significant.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  64  extended load data; 0 for stores and errors.
- resp_error  out  1  qualified by resp_valid.
- Mem_Addr  out  64  memory byte address.
- Write_Data  out  64  memory write data.
- MemWrite  out  1  memory write strobe.
- MemRead  out  1  memory read strobe.
- Read_Data  in  64  memory read data, registered by the memory on the clk edge where MemRead=1.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State = IDLE.
  - req_ready=1; resp_valid=0; resp_error=0; resp_rdata=0.
  - Mem_Addr=0; Write_Data=0; MemRead=0; MemWrite=0.
- Accept: on a rising edge with req_valid && req_ready, latch write, funct3, addr and wdata. req_ready=1 only in IDLE.
- Error check at accept; any one of the following gives an error:
  - addr > MEM_BYTES-8 (full 64-bit unsigned compare).
  - Misalignment: half-word with addr[0]!=0, word with addr[1:0]!=0, double-word with addr[2:0]!=0.
  - Illegal funct3: load funct3=111, or store funct3[2]=1.
- Error response: go directly to RESP with resp_error=1 and resp_rdata=0. No MemRead or MemWrite is ever asserted for an errored request.
- FSM states: IDLE, RD, CAP, WR, RESP. MemRead=1 only in RD, MemWrite=1 only in WR; both are decoded from the registered state.
  - Load: IDLE -> RD -> CAP -> RESP.
  - SD: IDLE -> WR -> RESP.
  - SB/SH/SW: IDLE -> RD -> CAP -> WR -> RESP.
  - Error: IDLE -> RESP.
  - RESP -> IDLE unconditionally.
- Memory outputs: Mem_Addr = latched addr throughout RD and WR. Write_Data = merge buffer (SD: wdata verbatim).
- CAP, load: resp_rdata <= Read_Data[N-1:0] extended to 64 bits.
  - N = 8, 16, 32 or 64.
  - Signed loads replicate bit N-1; LBU/LHU/LWU zero-fill.
- CAP, store: merge buffer <= Read_Data with bytes [N/8-1:0] replaced by wdata[N-1:0]. Upper bytes are preserved, so neighbouring memory bytes are rewritten unchanged.
- RESP: resp_valid=1 for exactly one cycle. resp_rdata and resp_error hold until the next acceptance.
- Latency, counted in cycles after the accepting edge to the resp_valid cycle: error 1, SD 2, load 3, SB/SH/SW 4.
- No back-to-back overlap: a new request can be accepted in the cycle after RESP at the earliest.
- req_* inputs are ignored while req_ready=0.
- Reset mid-operation:
  - MemRead and MemWrite drop immediately and the request is discarded with no response.
  - A reset asserted before the WR-state edge prevents that write.

Test Plan:
- After reset with memory preloaded to 0x0D per byte: LD addr 0 -> MemRead high one cycle, resp_valid 3 cycles after accept, resp_rdata=0x0D0D0D0D0D0D0D0D, resp_error=0.
- SB addr 8 wdata 0x11223344556677AB -> RD then WR, Write_Data=0x0D0D0D0D0D0D0DAB, resp_valid at cycle 4. Then LD 8 -> 0x0D0D0D0D0D0D0DAB, LB 8 -> 0xFFFFFFFFFFFFFFAB, LBU 8 -> 0x00000000000000AB.
- SW addr 16 wdata 0x80000000 then LW 16 -> 0xFFFFFFFF80000000; LWU 16 -> 0x0000000080000000; LD 16 -> 0x0D0D0D0D80000000.
- Errors, each giving resp_valid at cycle 1 with resp_error=1 and MemRead=MemWrite=0 throughout: SH addr 9 (misaligned); LD addr 57 (out of range); load funct3=111 (illegal). LD addr 56 -> succeeds.
- Hold req_valid=1 continuously with two SD requests (addr 0, addr 24) -> second accepted only in the cycle after the first resp_valid; req_ready=0 in WR and RESP.
- Assert reset_n=0 during CAP of an SB to addr 32 -> MemWrite never asserts, no resp_valid; a subsequent LD 32 returns 0x0D0D0D0D0D0D0D0D.
